// File: rtl/vga_scan_reader.sv
// ---------------------------------------------------------------------------
// vga_scan_reader
//
// Reads a frame buffer and scans it out as VGA video. It generates the
// horizontal and vertical timing (640x480 at 60 Hz with the default
// parameters) and drives the buffer read address. It registers the returned
// 12-bit pixel onto the RGB pins. The stored image is smaller than the screen.
// Each buffer pixel is repeated (1 << SCALE_SHIFT) times in both directions.
// Video is forced to black until the display is enabled. Enable and disable
// requests only take effect at the end of a frame, so a frame is never torn.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   pix_en         pixel-rate tick; timing and outputs advance only when high
//   display_enable request to show buffer contents, sampled at frame end
//   pixel_out      buffer read data {R[11:8],G[7:4],B[3:0]}, combinational
//                  from row_read/col_read
//   row_read       buffer read row
//   col_read       buffer read column
//   vga_r/g/b      4-bit colour outputs
//   vga_hsync      horizontal sync, active low
//   vga_vsync      vertical sync, active low
//   frame_start    one-clock pulse when the counters return to (0,0)
//   displaying     high while the display is enabled (ACTIVE state)
// ---------------------------------------------------------------------------
module vga_scan_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        display_enable,
  input  logic [11:0] pixel_out,
  output logic [7:0]  row_read,
  output logic [8:0]  col_read,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start,
  output logic        displaying
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;

  logic h_at_last;
  logic v_at_last;
  logic frame_end;
  logic hs_raw;
  logic vs_raw;
  logic active_raw;

  // Position decode. frame_end marks the single tick that closes a frame.
  // Both the state machine and the frame_start pulse key off that tick.
  assign h_at_last  = (h_cnt_q == H_LAST);
  assign v_at_last  = (v_cnt_q == V_LAST);
  assign frame_end  = pix_en && h_at_last && v_at_last;
  assign active_raw = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_raw     = !((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST));
  assign vs_raw     = !((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST));

  // The buffer address is the screen position divided down by the scale
  // factor. It is parked at 0 in the blanking regions so the buffer sees a
  // legal address.
  always_comb begin
    col_read = 9'd0;
    row_read = 8'd0;
    if (h_cnt_q < H_VIS) begin
      col_read = 9'(h_cnt_q >> SCALE_SHIFT);
    end
    if (v_cnt_q < V_VIS) begin
      row_read = 8'(v_cnt_q >> SCALE_SHIFT);
    end
  end

  // Raster counters. The vertical counter only moves when a line wraps.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_at_last) begin
        h_cnt_d = 10'd0;
        v_cnt_d = v_at_last ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Output pipeline stage. Syncs and colour go through the same register.
  // This keeps them aligned with each other, one tick behind the counters.
  // Colour is gated with the current state. A state change lands on the
  // frame-end tick, which is in blanking, so a frame is never partly shown.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = frame_end;
    if (pix_en) begin
      hsync_d = hs_raw;
      vsync_d = vs_raw;
      rgb_d   = (active_raw && (state_q == ACTIVE)) ? pixel_out : 12'h000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Display state machine: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Display state machine: next state. display_enable is only looked at on
  // the frame-end tick. A toggle or pulse at any other time is ignored.
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      case (state_q)
        IDLE:    if (display_enable)  state_d = ACTIVE;
        ACTIVE:  if (!display_enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Display state machine: outputs.
  always_comb begin
    displaying = (state_q == ACTIVE);
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_reader
//
// Drives vga_scan_reader with shrunken timing so that whole frames are
// short. The reference model tracks the raster position as a plain tick
// count since reset. Position, sync windows and colour are derived from that
// count with division and modulo. The model also holds the display state it
// expects at each frame boundary.
// ---------------------------------------------------------------------------
module tb_vga_scan_reader;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        display_enable;
  logic [11:0] pixel_out;
  logic [7:0]  row_read;
  logic [8:0]  col_read;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, frame_start, displaying;

  vga_scan_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .display_enable(display_enable),
    .pixel_out(pixel_out),
    .row_read(row_read),
    .col_read(col_read),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .frame_start(frame_start),
    .displaying(displaying)
  );

  always #5 clk = ~clk;

  // Frame buffer stand-in. Its contents are a recognisable function of the
  // address.
  assign pixel_out = {row_read[3:0], col_read[7:0]};

  typedef struct {
    int frames;
    int period;
    bit de;
    bit randDe;
    bit expDisp;
  } phase_t;

  phase_t phases[6];

  int total = 0;
  int bad   = 0;

  int          t;
  bit          mActive;
  bit          expHs, expVs, expFs;
  logic [11:0] expRgb;

  int target, cyc, sinceFs, seen, gap, guard;
  bit pe, de, atEnd;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    t       = 0;
    mActive = 1'b0;
    expHs   = 1'b1;
    expVs   = 1'b1;
    expRgb  = 12'h000;
    expFs   = 1'b0;
  endtask

  // One clock with the given inputs. The model advances alongside the DUT,
  // then every output is compared at posedge+1.
  task automatic applyStimulus(input bit pe_i, input bit de_i);
    int preH, preV, nh, nv, expCol, expRow;
    preH = t % HT;
    preV = (t / HT) % VT;
    pix_en         = pe_i;
    display_enable = de_i;
    @(posedge clk);
    #1;
    expFs = 1'b0;
    if (pe_i) begin
      expHs = !(preH >= HA + HF && preH < HA + HF + HS);
      expVs = !(preV >= VA + VF && preV < VA + VF + VS);
      if (preH < HA && preV < VA && mActive)
        expRgb = {4'(preV >> 1), 8'(preH >> 1)};
      else
        expRgb = 12'h000;
      if (preH == 5 && preV == 7 && mActive)
        checkOutput("rgb_at_h5_v7", 32'({vga_r, vga_g, vga_b}), 32'h302);
      if (preH == HT - 1 && preV == VT - 1) begin
        expFs   = 1'b1;
        mActive = de_i;
      end
      t++;
    end
    checkOutput("outputs", 32'({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start, displaying}),
                32'({expHs, expVs, expRgb, expFs, mActive}));
    nh = t % HT;
    nv = (t / HT) % VT;
    expCol = (nh < HA) ? (nh >> 1) : 0;
    expRow = (nv < VA) ? (nv >> 1) : 0;
    checkOutput("address", 32'({row_read, col_read}), 32'({8'(expRow), 9'(expCol)}));
  endtask

  // Tick with pix_en=1 until the model is sitting at position (h,v).
  task automatic runTo(input int h, input int v, input bit de_i);
    int g;
    g = 0;
    while (!((t % HT) == h && ((t / HT) % VT) == v) && g < 2 * FT) begin
      applyStimulus(1'b1, de_i);
      g++;
    end
  endtask

  initial begin
    phases[0] = '{frames: 2, period: 1, de: 1'b0, randDe: 1'b0, expDisp: 1'b0};
    phases[1] = '{frames: 1, period: 1, de: 1'b1, randDe: 1'b1, expDisp: 1'b1};
    phases[2] = '{frames: 1, period: 4, de: 1'b1, randDe: 1'b0, expDisp: 1'b1};
    phases[3] = '{frames: 1, period: 0, de: 1'b0, randDe: 1'b1, expDisp: 1'b0};
    phases[4] = '{frames: 2, period: 2, de: 1'b1, randDe: 1'b0, expDisp: 1'b1};
    phases[5] = '{frames: 1, period: 0, de: 1'b1, randDe: 1'b1, expDisp: 1'b1};

    reset          = 1'b1;
    pix_en         = 1'b0;
    display_enable = 1'b0;
    resetModel();
    #12;
    checkOutput("reset_outputs", 32'({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start, displaying}),
                32'h0000C000);
    checkOutput("reset_address", 32'({row_read, col_read}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table phases; each covers whole frames so the next starts at (0,0).
    for (int p = 0; p < 6; p++) begin
      target = t + phases[p].frames * FT;
      cyc    = 0;
      while (t < target && cyc < phases[p].frames * FT * 8) begin
        if (phases[p].period == 0)
          pe = 1'($urandom_range(0, 1));
        else
          pe = (cyc % phases[p].period) == 0;
        atEnd = ((t % HT) == HT - 1) && (((t / HT) % VT) == VT - 1);
        if (phases[p].randDe && !atEnd)
          de = 1'($urandom_range(0, 1));
        else
          de = phases[p].de;
        applyStimulus(pe, de);
        cyc++;
      end
      checkOutput($sformatf("phase%0d_ticks", p), 32'(t), 32'(target));
      checkOutput($sformatf("phase%0d_displaying", p), 32'(displaying), 32'(phases[p].expDisp));
    end

    // frame_start spacing with pix_en held high.
    sinceFs = 0;
    seen    = 0;
    gap     = -1;
    guard   = 0;
    while (seen < 2 && guard < 3 * FT) begin
      applyStimulus(1'b1, 1'b1);
      sinceFs++;
      guard++;
      if (frame_start) begin
        if (seen > 0) gap = sinceFs;
        seen++;
        sinceFs = 0;
      end
    end
    checkOutput("frame_start_gap", 32'(gap), 32'(FT));

    // Drop the enable mid-frame. The frame finishes showing, then goes dark.
    runTo(0, 6, 1'b1);
    runTo(HT - 1, VT - 1, 1'b0);
    checkOutput("disp_before_frame_end", 32'(displaying), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("disp_after_frame_end", 32'(displaying), 32'd0);

    // Short enable pulse inside one line of an idle frame.
    runTo(3, 5, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);
    runTo(0, 0, 1'b0);
    checkOutput("pulse_ignored", 32'(displaying), 32'd0);

    // Enable, then hit the reset asynchronously in the middle of a frame.
    runTo(HT - 1, VT - 1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    runTo(10, 6, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_outputs", 32'({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start, displaying}),
                32'h0000C000);
    checkOutput("async_reset_address", 32'({row_read, col_read}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    resetModel();
    runTo(HT - 1, VT - 1, 1'b0);
    checkOutput("idle_after_reset", 32'(displaying), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("enabled_after_reset", 32'(displaying), 32'd1);
    runTo(0, 9, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
